// File: rtl/framebuffer_swap_ctrl.sv
// framebuffer_swap_ctrl
//
// Double-buffer controller between a pixel renderer and a scanout engine.
// The renderer writes into the back buffer with zero latency while the
// controller is idle. When the renderer signals frame completion, the
// controller waits for vertical blanking, flips the front/back buffer
// selection, counts the swap and (optionally) sweeps the new back buffer
// with CLEAR_COLOR before handing it back to the renderer.
//
// Ports:
//   clk         sole clock, rising edge
//   rst         synchronous, active-high reset
//   vblank      scanout is in vertical blanking
//   swap_req    renderer frame-complete pulse
//   rend_we     renderer write strobe
//   rend_addr   renderer pixel address
//   rend_data   renderer pixel value
//   rend_ready  renderer writes are accepted this cycle
//   swap_busy   swap pending or clear sweep in progress
//   front_sel   buffer index read by scanout
//   wr_en       buffer write enable
//   wr_sel      buffer index written
//   wr_addr     buffer write address
//   wr_data     buffer write data
//   swap_count  completed swaps, modulo 256
//   addr_err    sticky flag: an out-of-range renderer write was dropped
module framebuffer_swap_ctrl #(
  parameter int WIDTH      = 160,
  parameter int HEIGHT     = 120,
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = $clog2(WIDTH * HEIGHT),
  parameter logic [DATA_WIDTH-1:0] CLEAR_COLOR = '0,
  parameter bit CLEAR_EN   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vblank,
  input  logic                  swap_req,
  input  logic                  rend_we,
  input  logic [ADDR_WIDTH-1:0] rend_addr,
  input  logic [DATA_WIDTH-1:0] rend_data,
  output logic                  rend_ready,
  output logic                  swap_busy,
  output logic                  front_sel,
  output logic                  wr_en,
  output logic                  wr_sel,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [7:0]            swap_count,
  output logic                  addr_err
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VBLANK,
    SWAP,
    CLEAR
  } state_t;

  localparam int PIXELS = WIDTH * HEIGHT;
  localparam int LIMIT_WIDTH = ADDR_WIDTH + 1;

  // One extra bit so the pixel count still fits when it is an exact power of two.
  localparam logic [ADDR_WIDTH:0]   PIXEL_LIMIT = LIMIT_WIDTH'(PIXELS);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(PIXELS - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE    = ADDR_WIDTH'(1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] clear_addr;
  logic                  busy_q;
  logic                  front_q;
  logic                  err_q;
  logic [7:0]            count_q;
  logic                  addr_ok;

  assign addr_ok = ({1'b0, rend_addr} < PIXEL_LIMIT);

  // Control FSM. busy_q is updated together with every state transition so
  // swap_busy is a registered copy of "state is not IDLE" with no decode
  // glitches. Renderer strobes and swap requests only matter in IDLE;
  // vblank only matters while waiting for it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy_q     <= 1'b0;
      front_q    <= 1'b0;
      err_q      <= 1'b0;
      count_q    <= 8'd0;
      clear_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rend_we && !addr_ok) begin
            err_q <= 1'b1;
          end
          if (swap_req) begin
            state  <= WAIT_VBLANK;
            busy_q <= 1'b1;
          end
        end
        WAIT_VBLANK: begin
          if (vblank) begin
            state <= SWAP;
          end
        end
        SWAP: begin
          front_q    <= ~front_q;
          count_q    <= count_q + 8'd1;
          clear_addr <= '0;
          if (CLEAR_EN) begin
            state <= CLEAR;
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        CLEAR: begin
          if (clear_addr == LAST_ADDR) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            clear_addr <= clear_addr + ADDR_ONE;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Buffer write port. In IDLE the renderer drives the back buffer directly
  // (same-cycle pass-through, out-of-range addresses dropped); during CLEAR
  // the sweep owns the port. wr_sel always points at the back buffer, which
  // after a swap is the buffer scanout just released.
  always_comb begin
    rend_ready = 1'b0;
    wr_en      = 1'b0;
    wr_sel     = ~front_q;
    wr_addr    = rend_addr;
    wr_data    = rend_data;
    case (state)
      IDLE: begin
        rend_ready = 1'b1;
        wr_en      = rend_we && addr_ok;
      end
      CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = clear_addr;
        wr_data = CLEAR_COLOR;
      end
      default: begin
      end
    endcase
  end

  assign swap_busy  = busy_q;
  assign front_sel  = front_q;
  assign swap_count = count_q;
  assign addr_err   = err_q;

endmodule

// File: doc/framebuffer_swap_ctrl.md
FRAMEBUFFER_SWAP_CTRL -- requirements
Module: framebuffer_swap_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 160, frame width in pixels.
REQ-002 SHALL have parameter HEIGHT, default 120, frame height in pixels.
REQ-003 SHALL have parameter DATA_WIDTH, default 12, pixel width in bits.
REQ-004 SHALL have parameter ADDR_WIDTH, default $clog2(WIDTH*HEIGHT) (15), pixel address width.
REQ-005 SHALL have parameter CLEAR_COLOR, default 12'h000, value written by the clear sweep.
REQ-006 SHALL have parameter CLEAR_EN, default 1; 1 enables the post-swap clear sweep.
REQ-007 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-008 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-009 SHALL have port vblank  input  1  scanout is in vertical blanking.
REQ-010 SHALL have port swap_req  input  1  renderer frame-complete pulse.
REQ-011 SHALL have port rend_we  input  1  renderer write strobe.
REQ-012 SHALL have port rend_addr  input  ADDR_WIDTH  renderer pixel address.
REQ-013 SHALL have port rend_data  input  DATA_WIDTH  renderer pixel value.
REQ-014 SHALL have port rend_ready  output  1  renderer writes accepted this cycle.
REQ-015 SHALL have port swap_busy  output  1  swap pending or clear in progress.
REQ-016 SHALL have port front_sel  output  1  buffer index read by scanout.
REQ-017 SHALL have port wr_en  output  1  buffer write enable.
REQ-018 SHALL have port wr_sel  output  1  buffer index written.
REQ-019 SHALL have port wr_addr  output  ADDR_WIDTH  buffer write address.
REQ-020 SHALL have port wr_data  output  DATA_WIDTH  buffer write data.
REQ-021 SHALL have port swap_count  output  8  completed swaps, modulo 256.
REQ-022 SHALL have port addr_err  output  1  sticky: out-of-range renderer write dropped.

Function
REQ-023 SHALL implement FSM states IDLE, WAIT_VBLANK, SWAP, CLEAR.
REQ-024 IDLE: rend_ready=1; wr_en=rend_we AND rend_addr<WIDTH*HEIGHT; wr_sel=~front_sel; wr_addr/wr_data=rend_addr/rend_data, combinational, zero latency.
REQ-025 IDLE with rend_we=1 and rend_addr>=WIDTH*HEIGHT: SHALL suppress wr_en and set addr_err next cycle; addr_err clears only on rst.
REQ-026 IDLE with swap_req=1: next state WAIT_VBLANK; a renderer write in that same cycle SHALL still be performed.
REQ-027 WAIT_VBLANK: rend_ready=0, wr_en=0; vblank sampled 1 -> next state SWAP, including when vblank is already high on entry.
REQ-028 SWAP (one cycle): wr_en=0; front_sel toggles (new value visible next cycle); swap_count increments with wrap 255->0; clear address reset to 0; next state CLEAR if CLEAR_EN=1, else IDLE.
REQ-029 CLEAR: wr_en=1, wr_sel=~front_sel (new back buffer), wr_addr=clear address, wr_data=CLEAR_COLOR; address increments by 1 per cycle.
REQ-030 CLEAR at address WIDTH*HEIGHT-1: last write, next state IDLE; sweep lasts exactly WIDTH*HEIGHT cycles.
REQ-031 swap_busy SHALL be 1 exactly when state is not IDLE (registered state decode).
REQ-032 swap_req outside IDLE SHALL be ignored (not queued); rend_we outside IDLE SHALL be ignored without setting addr_err.
REQ-033 vblank SHALL have no effect outside WAIT_VBLANK.

Reset
REQ-034 rst=1 SHALL force state IDLE, front_sel=0, swap_count=0, addr_err=0, clear address=0 on the next edge, overriding all other inputs.
REQ-035 rst mid-WAIT_VBLANK or mid-CLEAR SHALL abort without finishing; buffer contents are not restored or cleared.
REQ-036 During and after reset, in IDLE with rend_we=0: wr_en=0, swap_busy=0, rend_ready=1.

Verification
REQ-037 After reset: rend_we=1, addr=5, data=12'hABC -> same cycle wr_en=1, wr_sel=1, wr_addr=5, wr_data=12'hABC.
REQ-038 swap_req at cycle N, vblank low until cycle V -> swap_busy=1 from N+1; front_sel=1 at V+2; CLEAR writes 12'h000 to buffer 0 at addresses 0..19199 over cycles V+2..V+19201; swap_busy=0 at V+19202; swap_count=1.
REQ-039 swap_req and rend_we pulsed during CLEAR -> no queued swap, no renderer write, swap_count unchanged, rend_ready=0.
REQ-040 rend_we=1, rend_addr=19200 in IDLE -> wr_en=0, addr_err=1 next cycle and stays 1 until rst.
REQ-041 rst asserted at clear address 1000 -> next cycle state IDLE, front_sel=0, swap_count=0, wr_en=0, swap_busy=0.
REQ-042 CLEAR_EN=0, 256 swaps with vblank tied high -> each swap busy for 2 cycles after swap_req, no CLEAR writes, swap_count wraps to 0, front_sel=0.
